inst_fifo: RTL and testbench

//  Dual-issue instruction buffer between fetch and decode. Fetch pushes 0-2 {pc,inst} pairs per cycle;

---
 rtl/inst_fifo_pkg.sv | 14 +
 rtl/inst_fifo_if.sv | 42 ++++
 rtl/inst_fifo_ram.sv | 34 +++
 rtl/inst_fifo.sv | 104 ++++++++++
 tb/tb_inst_fifo.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/inst_fifo_pkg.sv
// Shared definitions for the fetch/decode instruction buffer.
//   DEF_PC_W / DEF_INST_W : default pc and instruction widths
//   DEF_DEPTH             : default buffer depth
//   fifo_entry_t          : one buffered {pc, inst} pair
package cdim_pkg;
  localparam int DEF_PC_W   = 32;
  localparam int DEF_INST_W = 32;
  localparam int DEF_DEPTH  = 16;

  typedef struct packed {
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_INST_W-1:0] inst;
  } fifo_entry_t;
endpackage

// File: rtl/inst_fifo_if.sv
// Fetch/decode side bundle of the instruction buffer.
//   master : fetch/decode/hazard side (drives i_*, observes o_*)
//   slave  : the buffer itself
interface inst_fifo_if #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              i_flush;
  logic              i_we0;
  logic              i_we1;
  logic [PC_W-1:0]   i_pc0;
  logic [INST_W-1:0] i_inst0;
  logic [PC_W-1:0]   i_pc1;
  logic [INST_W-1:0] i_inst1;
  logic              i_re0;
  logic              i_re1;
  logic [PC_W-1:0]   o_pc0;
  logic [INST_W-1:0] o_inst0;
  logic              o_valid0;
  logic [PC_W-1:0]   o_pc1;
  logic [INST_W-1:0] o_inst1;
  logic              o_valid1;
  logic              o_empty;
  logic              o_almost_empty;
  logic              o_full;
  logic [CNT_W-1:0]  o_count;

  modport master (
    output i_flush, i_we0, i_we1, i_pc0, i_inst0, i_pc1, i_inst1, i_re0, i_re1,
    input  o_pc0, o_inst0, o_valid0, o_pc1, o_inst1, o_valid1,
           o_empty, o_almost_empty, o_full, o_count
  );

  modport slave (
    input  i_flush, i_we0, i_we1, i_pc0, i_inst0, i_pc1, i_inst1, i_re0, i_re1,
    output o_pc0, o_inst0, o_valid0, o_pc1, o_inst1, o_valid1,
           o_empty, o_almost_empty, o_full, o_count
  );
endinterface

// File: rtl/inst_fifo_ram.sv
// Storage for the instruction buffer: DEPTH x W entries.
//   i_we0/i_we1 : write slot 0 at i_waddr, slot 1 at i_waddr+1 (mod DEPTH)
//   i_raddr     : head index; o_rdata0/o_rdata1 are head and head+1 (async read)
// Slot 1 always targets a different index than slot 0, so no write collision.
module inst_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we0,
  input  logic             i_we1,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata0,
  input  logic [W-1:0]     i_wdata1,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [W-1:0]     o_rdata0,
  output logic [W-1:0]     o_rdata1
);
  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] w_waddr1;
  logic [PTR_W-1:0] w_raddr1;

  assign w_waddr1 = i_waddr + PTR_W'(1);
  assign w_raddr1 = i_raddr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_waddr] <= i_wdata0;
    if (i_we1) r_mem[w_waddr1] <= i_wdata1;
  end

  assign o_rdata0 = r_mem[i_raddr];
  assign o_rdata1 = r_mem[w_raddr1];
endmodule

// File: rtl/inst_fifo.sv
// Dual-issue instruction buffer between fetch and decode.
//   clk, resetn : clock, async active-low reset
//   bus (slave) : 0-2 pushes and 0-2 pops per cycle, flush, status flags
// Pops are clipped to the occupancy; a push that would overflow is dropped whole.
// Flush wins over push and pop in the same cycle.
module inst_fifo
  import cdim_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PC_W   = DEF_PC_W,
  parameter int INST_W = DEF_INST_W
) (
  input  logic        clk,
  input  logic        resetn,
  inst_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int W     = PC_W + INST_W;

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_pop0;
  logic             w_pop1;
  logic [1:0]       w_nr;
  logic [1:0]       w_nw_req;
  logic [CNT_W:0]   w_after;
  logic             w_accept;
  logic             w_we0;
  logic             w_we1;
  logic [1:0]       w_nw;
  logic [W-1:0]     w_rdata0;
  logic [W-1:0]     w_rdata1;

  // Clip pops to what is actually held.
  assign w_pop0 = bus.i_re0 && (r_count != '0);
  assign w_pop1 = bus.i_re0 && bus.i_re1 && (r_count >= CNT_W'(2));
  assign w_nr   = {1'b0, w_pop0} + {1'b0, w_pop1};

  assign w_nw_req = {1'b0, bus.i_we0} + {1'b0, bus.i_we0 & bus.i_we1};

  // Occupancy after this cycle's pop and push; same-cycle pop frees space.
  assign w_after  = {1'b0, r_count} - (CNT_W+1)'(w_nr) + (CNT_W+1)'(w_nw_req);
  assign w_accept = (w_after <= (CNT_W+1)'(DEPTH)) && !bus.i_flush;

  assign w_we0 = bus.i_we0 && w_accept;
  assign w_we1 = bus.i_we0 && bus.i_we1 && w_accept;
  assign w_nw  = w_accept ? w_nw_req : 2'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_nr);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_nw);
      r_count  <= r_count - CNT_W'(w_nr) + CNT_W'(w_nw);
    end
  end

  inst_fifo_ram #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_ram (
    .clk      (clk),
    .i_we0    (w_we0),
    .i_we1    (w_we1),
    .i_waddr  (r_wr_ptr),
    .i_wdata0 ({bus.i_pc0, bus.i_inst0}),
    .i_wdata1 ({bus.i_pc1, bus.i_inst1}),
    .i_raddr  (r_rd_ptr),
    .o_rdata0 (w_rdata0),
    .o_rdata1 (w_rdata1)
  );

  assign bus.o_pc0          = w_rdata0[W-1:INST_W];
  assign bus.o_inst0        = w_rdata0[INST_W-1:0];
  assign bus.o_pc1          = w_rdata1[W-1:INST_W];
  assign bus.o_inst1        = w_rdata1[INST_W-1:0];
  assign bus.o_valid0       = (r_count >= CNT_W'(1));
  assign bus.o_valid1       = (r_count >= CNT_W'(2));
  assign bus.o_empty        = (r_count == '0);
  assign bus.o_almost_empty = (r_count == CNT_W'(1));
  assign bus.o_full         = (r_count > CNT_W'(DEPTH - 2));
  assign bus.o_count        = r_count;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(bus.i_we1 && !bus.i_we0))
        else $error("inst_fifo: protocol error, i_we1 without i_we0");
      assert (!(bus.i_re1 && !bus.i_re0))
        else $error("inst_fifo: protocol error, i_re1 without i_re0");
    end
  end
`endif
endmodule

// File: tb/tb_inst_fifo.sv
module tb_inst_fifo;
  import cdim_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  inst_fifo_if #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) bus();

  inst_fifo #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered queue of held entries.
  fifo_entry_t model[$];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model.delete();
    end else if (bus.i_flush) begin
      model.delete();
    end else begin
      int np;
      int nw;
      fifo_entry_t e;
      np = bus.i_re0 ? (bus.i_re1 ? 2 : 1) : 0;
      if (np > model.size()) np = model.size();
      for (int k = 0; k < np; k++) void'(model.pop_front());
      nw = bus.i_we0 ? (bus.i_we1 ? 2 : 1) : 0;
      if (model.size() + nw <= DEPTH) begin
        if (nw >= 1) begin e.pc = bus.i_pc0; e.inst = bus.i_inst0; model.push_back(e); end
        if (nw == 2) begin e.pc = bus.i_pc1; e.inst = bus.i_inst1; model.push_back(e); end
      end
    end
  end

  always @(negedge clk) begin
    int n;
    n = model.size();
    chk("count", 64'(bus.o_count), 64'(n));
    chk("empty", 64'(bus.o_empty), 64'(n == 0));
    chk("almost_empty", 64'(bus.o_almost_empty), 64'(n == 1));
    chk("full", 64'(bus.o_full), 64'(n > DEPTH - 2));
    chk("valid0", 64'(bus.o_valid0), 64'(n >= 1));
    chk("valid1", 64'(bus.o_valid1), 64'(n >= 2));
    if (n >= 1) begin
      chk("pc0", 64'(bus.o_pc0), 64'(model[0].pc));
      chk("inst0", 64'(bus.o_inst0), 64'(model[0].inst));
    end
    if (n >= 2) begin
      chk("pc1", 64'(bus.o_pc1), 64'(model[1].pc));
      chk("inst1", 64'(bus.o_inst1), 64'(model[1].inst));
    end
  end

  task automatic drive(input logic fl, input logic w0, input logic w1,
                       input logic [31:0] p0, input logic [31:0] p1,
                       input logic r0, input logic r1);
    bus.i_flush = fl;
    bus.i_we0   = w0;
    bus.i_we1   = w1;
    bus.i_pc0   = p0;
    bus.i_inst0 = inst_of(p0);
    bus.i_pc1   = p1;
    bus.i_inst1 = inst_of(p1);
    bus.i_re0   = r0;
    bus.i_re1   = r1;
  endtask

  // Apply one cycle of inputs; returns 1 time unit after the edge.
  task automatic step(input logic fl, input logic w0, input logic w1,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input logic r0, input logic r1);
    drive(fl, w0, w1, p0, p1, r0, r1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] head;
    drive(0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 64'(bus.o_empty), 64'd1);
    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_full", 64'(bus.o_full), 64'd0);
    resetn = 1'b1;
    idle();

    // 1. reset mid-traffic with 7 held
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h8 * i, 32'h8 * i + 4, 0, 0);
    step(0, 1, 0, 32'h18, 0, 0, 0);
    chk("t1_count7", 64'(bus.o_count), 64'd7);
    drive(0, 1, 1, 32'h20, 32'h24, 1, 0);
    #2;
    resetn = 1'b0;
    #1;
    chk("t1_rst_empty", 64'(bus.o_empty), 64'd1);
    chk("t1_rst_count", 64'(bus.o_count), 64'd0);
    chk("t1_rst_valid0", 64'(bus.o_valid0), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    step(0, 1, 0, 32'h200, 0, 0, 0);
    chk("t1_after_pc0", 64'(bus.o_pc0), 64'h200);
    chk("t1_after_count", 64'(bus.o_count), 64'd1);
    step(1, 0, 0, 0, 0, 0, 0);

    // 2. fill to 16, overflow dropped
    for (int i = 0; i < 7; i++) step(0, 1, 1, 32'h100 + 8 * i, 32'h104 + 8 * i, 0, 0);
    chk("t2_count14", 64'(bus.o_count), 64'd14);
    chk("t2_full14", 64'(bus.o_full), 64'd0);
    step(0, 1, 0, 32'h138, 0, 0, 0);
    chk("t2_full15", 64'(bus.o_full), 64'd1);
    step(0, 1, 0, 32'h13C, 0, 0, 0);
    chk("t2_count16", 64'(bus.o_count), 64'd16);
    step(0, 1, 1, 32'hDEAD0, 32'hDEAD4, 0, 0);
    step(0, 1, 0, 32'hBEEF0, 0, 0, 0);
    chk("t2_drop_count", 64'(bus.o_count), 64'd16);
    chk("t2_drop_head", 64'(bus.o_pc0), 64'h100);

    // 3. drain two per cycle
    for (int k = 0; k < 8; k++) begin
      chk("t3_pc0", 64'(bus.o_pc0), 64'(32'h100 + 8 * k));
      chk("t3_pc1", 64'(bus.o_pc1), 64'(32'h104 + 8 * k));
      chk("t3_almost_empty", 64'(bus.o_almost_empty), 64'd0);
      step(0, 0, 0, 0, 0, 1, 1);
    end
    chk("t3_empty", 64'(bus.o_empty), 64'd1);

    // full + same-cycle pop/push: the freed slot is usable
    for (int i = 0; i < 8; i++) step(0, 1, 1, 32'h300 + 8 * i, 32'h304 + 8 * i, 0, 0);
    step(0, 1, 1, 32'h340, 32'h344, 1, 1);
    chk("full_swap_count", 64'(bus.o_count), 64'd16);
    chk("full_swap_head", 64'(bus.o_pc0), 64'h308);
    step(1, 0, 0, 0, 0, 0, 0);

    // 4. wrap with steady push2/pop2
    pc = 32'h1000;
    head = 32'h1000;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, pc, pc + 4, 0, 0);
      pc += 8;
    end
    for (int i = 0; i < 40; i++) begin
      chk("t4_head", 64'(bus.o_pc0), 64'(head));
      step(0, 1, 1, pc, pc + 4, 1, 1);
      pc += 8;
      head += 8;
      chk("t4_count", 64'(bus.o_count), 64'd6);
    end
    step(1, 0, 0, 0, 0, 0, 0);

    // 5. clipping
    step(0, 1, 0, 32'h500, 0, 0, 0);
    chk("t5_almost_empty", 64'(bus.o_almost_empty), 64'd1);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("t5_clip2", 64'(bus.o_count), 64'd0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t5_clip1", 64'(bus.o_count), 64'd0);
    chk("t5_empty", 64'(bus.o_empty), 64'd1);

    // 6. flush beats push and pop
    for (int i = 0; i < 4; i++) step(0, 1, 1, 32'h600 + 8 * i, 32'h604 + 8 * i, 0, 0);
    step(0, 1, 0, 32'h620, 0, 0, 0);
    chk("t6_count9", 64'(bus.o_count), 64'd9);
    step(1, 1, 1, 32'h700, 32'h704, 1, 0);
    chk("t6_count", 64'(bus.o_count), 64'd0);
    chk("t6_empty", 64'(bus.o_empty), 64'd1);
    step(0, 1, 0, 32'h800, 0, 0, 0);
    chk("t6_after_pc0", 64'(bus.o_pc0), 64'h800);
    idle();

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
